// File: rtl/ahb_sram_pkg.sv
// Shared bus encodings, FSM state type and byte-lane helpers for the ahb_sram_ws slave.
package ahb_sram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_e;

    function automatic logic htrans_active(input logic [1:0] htrans);
        logic act;
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
            default:                   act = 1'b0;
        endcase
        return act;
    endfunction

    // Sizes above a word fall back to a full-word strobe; low address bits a size cannot use are ignored.
    function automatic logic [3:0] lane_strobe(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (size)
            HSIZE_BYTE: strb = 4'b0001 << addr_lo;
            HSIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:    strb = 4'b1111;
        endcase
        return strb;
    endfunction

    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            HSIZE_BYTE: bad = 1'b0;
            HSIZE_HALF: bad = addr_lo[0];
            HSIZE_WORD: bad = (addr_lo != 2'b00);
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Byte-strobed 32-bit synchronous RAM: one write port, one registered read port.
module ahb_sram_array #(
  parameter int    WORD_AW   = 12,
  parameter string INIT_FILE = ""
) (
  input  logic               clk,
  input  logic               we,
  input  logic [WORD_AW-1:0] waddr,
  input  logic [3:0]         wstrb,
  input  logic [31:0]        wdata,
  input  logic [WORD_AW-1:0] raddr,
  output logic [31:0]        rdata
);

  logic [31:0] mem [0:(1<<WORD_AW)-1];
  logic [31:0] rdata_q;

  // A read of the word being written on the same edge returns the old contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ahb_sram_ws.sv
// AHB-Lite SRAM slave with configurable data-phase wait states and write-to-read forwarding.
// Define AHB_SRAM_ALIGN_ERR_EN to answer misaligned or oversized transfers with a two-cycle ERROR.
module ahb_sram_ws
    import ahb_sram_pkg::*;
#(
    parameter int    ADDR_WIDTH  = 14,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int         WAW      = ADDR_WIDTH - 2;
    localparam logic [1:0] CNT_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

    state_e                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  dp_q, dp_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [2:0]            size_q, size_d;
    logic [31:0]           hold_q, hold_d;
    logic                  fwd_q, fwd_d;
    logic [3:0]            fwd_strb_q, fwd_strb_d;
    logic [31:0]           fwd_data_q, fwd_data_d;

    logic           accept, bad, final_cyc, wr_en, rd_final;
    logic [3:0]     wr_strb;
    logic [WAW-1:0] wr_word, rd_word;
    logic [31:0]    ram_rdata, merged, rdata_out;
    logic           unused_haddr;

    assign unused_haddr = ^HADDR[31:ADDR_WIDTH];
    assign accept       = HSEL & HREADY & HREADYOUT & htrans_active(HTRANS);

`ifdef AHB_SRAM_ALIGN_ERR_EN
    assign bad = misaligned(HSIZE, HADDR[1:0]);
`else
    assign bad = 1'b0;
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (bad) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 2'd0) state_d = ST_IDLE;
                else               cnt_d   = cnt_q - 2'd1;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        HREADYOUT = !(state_q == ST_WAIT || state_q == ST_ERR1);
        HRESP     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    end

    // dp_q marks an OKAY transfer whose data phase is still open; it ends in the first IDLE cycle.
    always_comb begin
        final_cyc = dp_q & (state_q == ST_IDLE);
        wr_en     = final_cyc & write_q;
        rd_final  = final_cyc & ~write_q;
        wr_strb   = lane_strobe(size_q, addr_q[1:0]);
        wr_word   = addr_q[ADDR_WIDTH-1:2];
        rd_word   = accept ? HADDR[ADDR_WIDTH-1:2] : addr_q[ADDR_WIDTH-1:2];

        dp_d    = final_cyc ? 1'b0 : dp_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        if (accept) begin
            dp_d    = ~bad;
            addr_d  = HADDR[ADDR_WIDTH-1:0];
            write_d = HWRITE;
            size_d  = HSIZE;
        end

        // Remember lanes committed on the same edge the array samples the read address.
        fwd_d      = wr_en & (wr_word == rd_word);
        fwd_strb_d = wr_strb;
        fwd_data_d = HWDATA;

        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = (fwd_q && fwd_strb_q[b]) ? fwd_data_q[8*b +: 8] : ram_rdata[8*b +: 8];
        end
        rdata_out = rd_final ? merged : hold_q;
        hold_d    = rdata_out;
    end

    assign HRDATA = rdata_out;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_q       <= 1'b0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            size_q     <= HSIZE_WORD;
            hold_q     <= 32'd0;
            fwd_q      <= 1'b0;
            fwd_strb_q <= 4'd0;
            fwd_data_q <= 32'd0;
        end else begin
            dp_q       <= dp_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            size_q     <= size_d;
            hold_q     <= hold_d;
            fwd_q      <= fwd_d;
            fwd_strb_q <= fwd_strb_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    ahb_sram_array #(
        .WORD_AW   (WAW),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk   (HCLK),
        .we    (wr_en),
        .waddr (wr_word),
        .wstrb (wr_strb),
        .wdata (HWDATA),
        .raddr (rd_word),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_ahb_sram_ws.sv
// Bench for ahb_sram_ws: a zero-wait instance and a two-wait instance against a byte-level memory model.
module tb_ahb_sram_ws;

    localparam int WS0   = 0;
    localparam int WS1   = 2;
    localparam int AW    = 14;
    localparam int MSIZE = 1 << AW;

    logic        HCLK, HRESETn;
    logic        hsel [2];
    logic        hwrite [2];
    logic        hreadyout [2];
    logic        hresp [2];
    logic        hready_block [2];
    logic [31:0] haddr [2];
    logic [31:0] hwdata [2];
    logic [31:0] hrdata [2];
    logic [1:0]  htrans [2];
    logic [2:0]  hsize [2];
    logic        hready_0, hready_1;

    int          checks = 0;
    int          failures = 0;
    int          ws0_lows = 0;
    logic [7:0]  mdl [2][MSIZE];
    logic [31:0] last_rd [2];
    logic [31:0] exp_q [$];

    typedef struct {
        int          k;
        bit          wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [$];

    // ---------------- clock / reset / DUTs ----------------
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    assign hready_0 = hready_block[0] ? 1'b0 : hreadyout[0];
    assign hready_1 = hready_block[1] ? 1'b0 : hreadyout[1];

    ahb_sram_ws #(.ADDR_WIDTH(AW), .WAIT_STATES(WS0), .INIT_FILE("")) dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[0]), .HREADY(hready_0), .HADDR(haddr[0]),
        .HTRANS(htrans[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HWDATA(hwdata[0]),
        .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0])
    );

    ahb_sram_ws #(.ADDR_WIDTH(AW), .WAIT_STATES(WS1), .INIT_FILE("")) dut1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[1]), .HREADY(hready_1), .HADDR(haddr[1]),
        .HTRANS(htrans[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HWDATA(hwdata[1]),
        .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1])
    );

    always @(negedge HCLK) begin
        if (HRESETn === 1'b1 && hreadyout[0] !== 1'b1) ws0_lows++;
    end

    // ---------------- helpers ----------------
    function automatic int ws_of(input int k);
        return (k == 0) ? WS0 : WS1;
    endfunction

    function automatic bit mis(input logic [2:0] size, input logic [31:0] a);
`ifdef AHB_SRAM_ALIGN_ERR_EN
        if (size > 3'd2) return 1'b1;
        return (a % (32'd1 << size)) != 0;
`else
        return (size > 3'd7) || (a === 32'hx);
`endif
    endfunction

    function automatic int nbytes(input logic [2:0] size);
        return (size == 3'd0) ? 1 : (size == 3'd1) ? 2 : 4;
    endfunction

    task automatic model_write(input int k, input logic [2:0] size, input logic [31:0] a, input logic [31:0] d);
        int n, base;
        n    = nbytes(size);
        base = (int'(a % MSIZE) / n) * n;
        for (int i = 0; i < n; i++) mdl[k][base + i] = d[8*((base + i) % 4) +: 8];
    endtask

    function automatic logic [31:0] model_read(input int k, input logic [31:0] a);
        int wa;
        wa = (int'(a % MSIZE) / 4) * 4;
        return {mdl[k][wa + 3], mdl[k][wa + 2], mdl[k][wa + 1], mdl[k][wa]};
    endfunction

    function automatic logic [31:0] rnd_addr();
        return ($urandom & 32'hFFFF_C000) | (32'h100 + 32'($urandom_range(0, 255)));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic bus_idle(input int k);
        hsel[k]   = 1'b0;
        htrans[k] = 2'b00;
        hwrite[k] = 1'b0;
        haddr[k]  = 32'd0;
        hsize[k]  = 3'b010;
    endtask

    task automatic addr_phase(input int k, input bit wr, input logic [2:0] size, input logic [31:0] a);
        hsel[k]   = 1'b1;
        htrans[k] = 2'b10;
        hwrite[k] = wr;
        hsize[k]  = size;
        haddr[k]  = a;
    endtask

    task automatic wait_ready(input int k, output int waits, output logic resp_first);
        waits      = 0;
        resp_first = hresp[k];
        while (hreadyout[k] !== 1'b1 && waits < 8) begin
            waits++;
            step();
        end
        if (hreadyout[k] !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL timeout inst%0d: HREADYOUT=%b required 1 within 8 cycles", k, hreadyout[k]);
        end
    endtask

    task automatic xfer(input int k, input bit wr, input logic [2:0] size, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rdata, output int waits,
                        output logic resp_first, output logic resp_last);
        addr_phase(k, wr, size, a);
        step();
        bus_idle(k);
        hwdata[k] = d;
        wait_ready(k, waits, resp_first);
        rdata     = hrdata[k];
        resp_last = hresp[k];
        step();
    endtask

    task automatic model_op(input int k, input bit wr, input logic [2:0] size, input logic [31:0] a,
                            input logic [31:0] d, input string tag);
        logic [31:0] rd, exp;
        int          w;
        logic        r1, r2;
        bit          err;
        err = mis(size, a);
        if (!wr && !err) exp_q.push_back(model_read(k, a));
        xfer(k, wr, size, a, d, rd, w, r1, r2);
        check({tag, " waits"}, 32'(w), err ? 32'd1 : 32'(ws_of(k)));
        check({tag, " hresp"}, {31'd0, r2}, {31'd0, err});
        if (err) check({tag, " hresp first"}, {31'd0, r1}, 32'd1);
        if (wr || err) begin
            check({tag, " hold"}, rd, last_rd[k]);
        end else begin
            exp = exp_q.pop_front();
            check({tag, " rdata"}, rd, exp);
            last_rd[k] = exp;
        end
        if (wr && !err) model_write(k, size, a, d);
    endtask

    // Write immediately followed by a word read whose address phase overlaps the write data phase.
    task automatic b2b(input int k, input logic [2:0] wsize, input logic [31:0] wa, input logic [31:0] d,
                       input logic [31:0] ra, input string tag);
        int   w;
        logic r;
        addr_phase(k, 1'b1, wsize, wa);
        step();
        hwdata[k] = d;
        addr_phase(k, 1'b0, 3'b010, ra);
        wait_ready(k, w, r);
        step();
        bus_idle(k);
        model_write(k, wsize, wa, d);
        exp_q.push_back(model_read(k, ra));
        wait_ready(k, w, r);
        check({tag, " waits"}, 32'(w), 32'(ws_of(k)));
        last_rd[k] = exp_q.pop_front();
        check({tag, " rdata"}, hrdata[k], last_rd[k]);
        step();
    endtask

    // ---------------- test ----------------
    initial begin
        logic [31:0] rd, wa, ra;
        int          w;
        logic        r1, r2;
        logic [2:0]  sz;

        vecs.push_back('{0, 1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000});
        vecs.push_back('{0, 1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF});
        vecs.push_back('{1, 1'b1, 3'b010, 32'h0000_0020, 32'h1122_3344, 32'h0000_0000});
        vecs.push_back('{1, 1'b0, 3'b010, 32'h0000_0020, 32'h0,         32'h1122_3344});
        vecs.push_back('{1, 1'b1, 3'b000, 32'h0000_0023, 32'hAA00_0000, 32'h1122_3344});
        vecs.push_back('{1, 1'b0, 3'b010, 32'h0000_0020, 32'h0,         32'hAA22_3344});
        vecs.push_back('{0, 1'b1, 3'b010, 32'h0000_4008, 32'h5566_7788, 32'hDEAD_BEEF});
        vecs.push_back('{0, 1'b0, 3'b010, 32'h0000_0008, 32'h0,         32'h5566_7788});
        vecs.push_back('{1, 1'b1, 3'b001, 32'h0000_0022, 32'hBEEF_0000, 32'hAA22_3344});
        vecs.push_back('{1, 1'b0, 3'b000, 32'h0000_0021, 32'h0,         32'hBEEF_3344});
        vecs.push_back('{0, 1'b1, 3'b000, 32'h0000_0011, 32'h0000_5A00, 32'h5566_7788});
        vecs.push_back('{0, 1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'hDEAD_5AEF});
        vecs.push_back('{0, 1'b1, 3'b010, 32'h0000_0040, 32'hA5A5_C3C3, 32'hDEAD_5AEF});
        vecs.push_back('{1, 1'b1, 3'b010, 32'h0000_0030, 32'h1234_5678, 32'hBEEF_3344});
        vecs.push_back('{0, 1'b1, 3'b010, 32'h0000_0050, 32'hCAFE_F00D, 32'hDEAD_5AEF});
`ifndef AHB_SRAM_ALIGN_ERR_EN
        vecs.push_back('{0, 1'b1, 3'b011, 32'h0000_0061, 32'h0A0B_0C0D, 32'hDEAD_5AEF});
        vecs.push_back('{0, 1'b1, 3'b001, 32'h0000_0063, 32'h7777_1111, 32'hDEAD_5AEF});
        vecs.push_back('{0, 1'b0, 3'b010, 32'h0000_0060, 32'h0,         32'h7777_0C0D});
`endif

        HRESETn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus_idle(k);
            hwdata[k]       = 32'd0;
            hready_block[k] = 1'b0;
            last_rd[k]      = 32'd0;
        end
        step();
        step();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset inst%0d HREADYOUT", k), {31'd0, hreadyout[k]}, 32'd1);
            check($sformatf("reset inst%0d HRESP", k),     {31'd0, hresp[k]},     32'd0);
            check($sformatf("reset inst%0d HRDATA", k),    hrdata[k],             32'd0);
        end
        HRESETn = 1'b1;
        step();

        for (int i = 0; i < vecs.size(); i++) begin
            xfer(vecs[i].k, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata, rd, w, r1, r2);
            check($sformatf("vec%0d rdata", i), rd, vecs[i].exp);
            check($sformatf("vec%0d waits", i), 32'(w), 32'(ws_of(vecs[i].k)));
            check($sformatf("vec%0d hresp", i), {31'd0, r2}, 32'd0);
            if (vecs[i].wr) model_write(vecs[i].k, vecs[i].size, vecs[i].addr, vecs[i].wdata);
            else            last_rd[vecs[i].k] = vecs[i].exp;
        end

        // Half write then same-word read, zero wait states: merged lanes must appear.
        b2b(0, 3'b001, 32'h0000_0042, 32'h1234_0000, 32'h0000_0040, "b2b half");
        check("b2b half const", hrdata[0], 32'h1234_C3C3);

        // Address phase presented while HREADY is low must be ignored.
        addr_phase(0, 1'b1, 3'b010, 32'h0000_0050);
        hwdata[0]       = 32'hFFFF_FFFF;
        hready_block[0] = 1'b1;
        step();
        bus_idle(0);
        hready_block[0] = 1'b0;
        step();
        step();
        model_op(0, 1'b0, 3'b010, 32'h0000_0050, 32'h0, "hready low");

`ifdef AHB_SRAM_ALIGN_ERR_EN
        addr_phase(1, 1'b1, 3'b010, 32'h0000_0031);
        step();
        bus_idle(1);
        hwdata[1] = 32'hFFFF_FFFF;
        check("err cycle1 HREADYOUT", {31'd0, hreadyout[1]}, 32'd0);
        check("err cycle1 HRESP",     {31'd0, hresp[1]},     32'd1);
        step();
        check("err cycle2 HREADYOUT", {31'd0, hreadyout[1]}, 32'd1);
        check("err cycle2 HRESP",     {31'd0, hresp[1]},     32'd1);
        check("err cycle2 HRDATA",    hrdata[1],             last_rd[1]);
        step();
        model_op(1, 1'b0, 3'b010, 32'h0000_0030, 32'h0, "err no write");
        model_op(1, 1'b1, 3'b011, 32'h0000_0030, 32'h0, "err oversize");
`endif

        // Reset asserted while a two-wait write is stalled.
        addr_phase(1, 1'b1, 3'b010, 32'h0000_0030);
        step();
        bus_idle(1);
        hwdata[1] = 32'hFFFF_0000;
        check("mid-write stalled", {31'd0, hreadyout[1]}, 32'd0);
        #2;
        HRESETn = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("async reset inst%0d HREADYOUT", k), {31'd0, hreadyout[k]}, 32'd1);
            check($sformatf("async reset inst%0d HRESP", k),     {31'd0, hresp[k]},     32'd0);
            check($sformatf("async reset inst%0d HRDATA", k),    hrdata[k],             32'd0);
            last_rd[k] = 32'd0;
        end
        step();
        step();
        HRESETn = 1'b1;
        step();
        model_op(1, 1'b0, 3'b010, 32'h0000_0030, 32'h0, "after reset word");
        check("after reset const", hrdata[1], 32'h1234_5678);

        // Random traffic on an initialised region, with random alias bits above ADDR_WIDTH.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 64; i++) begin
                model_op(k, 1'b1, 3'b010, 32'h100 + 32'(4 * i), $urandom, $sformatf("init%0d", k));
            end
            for (int i = 0; i < 120; i++) begin
                int r;
                r  = $urandom_range(0, 9);
                sz = 3'($urandom_range(0, 3));
                if (r < 4) begin
                    model_op(k, 1'b1, sz, rnd_addr(), $urandom, $sformatf("rnd%0d_%0d wr", k, i));
                end else if (r < 8) begin
                    model_op(k, 1'b0, sz, rnd_addr(), 32'h0, $sformatf("rnd%0d_%0d rd", k, i));
                end else begin
                    if (sz > 3'd2) sz = 3'd2;
                    wa = rnd_addr() & ~((32'd1 << sz) - 32'd1);
                    if ($urandom_range(0, 1) == 1) ra = ($urandom & 32'hFFFF_C000) | (wa & 32'h3FFC);
                    else                           ra = rnd_addr() & ~32'd3;
                    b2b(k, sz, wa, $urandom, ra, $sformatf("rnd%0d_%0d b2b", k, i));
                end
            end
        end

        check("ws0 HREADYOUT low cycles", 32'(ws0_lows), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
